// File: rtl/fsm_counter_pkg.sv
// Shared definitions for the step-counter scheduler: state encoding, default
// widths and the round-robin search used by the arbiter.
package fsm_counter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_STEP  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int STEP_W_DEF = 4;
    localparam int MAX_REQ    = 8;

    // First asserted request at or after (last+1) mod n, wrapping; returns last if none.
    function automatic logic [2:0] next_rr(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         last,
                                           input int                 n);
        logic [2:0] sel;
        logic       found;
        int         p;
        sel   = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            p = (int'(last) + k) % n;
            if (k <= n && !found && req[p[2:0]]) begin
                found = 1'b1;
                sel   = p[2:0];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/fsm_counter_sched_arbiter.sv
// Round-robin arbiter: one-hot winner plus binary index, searching upward
// from the requester after the last one served.
module rr_arbiter
    import fsm_counter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last,
    input  logic             en,
    output logic [N_REQ-1:0] win,
    output logic [2:0]       idx
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req;
        idx                  = next_rr(req_ext, last, N_REQ);
        win                  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win[i] = en && (|req) && (idx == 3'(i));
        end
    end

endmodule

// File: rtl/fsm_counter_sched.sv
// Shares one external mod-4 step counter among N_REQ requesters: grants one at a
// time, strobes din for the requested burst, then checks the counter result.
module fsm_counter_sched
    import fsm_counter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*STEP_W-1:0] steps,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic                    busy,
    output logic                    din,
    input  logic [1:0]              z,
    output logic [1:0]              exp_z,
    output logic                    err,
    output state_t                  dbg_state
);

    localparam logic [2:0] LAST_RST = 3'(N_REQ - 1);

    state_t            state, state_nx;
    logic [2:0]        last;
    logic [2:0]        widx;
    logic [2:0]        arb_idx;
    logic [N_REQ-1:0]  arb_win;
    logic [STEP_W-1:0] cnt;
    logic [STEP_W-1:0] cur_steps;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req  (req),
        .last (last),
        .en   (state == S_IDLE),
        .win  (arb_win),
        .idx  (arb_idx)
    );

    // Step count of the requester currently holding the grant.
    always_comb begin
        cur_steps = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (widx == 3'(i)) begin
                cur_steps = steps[i*STEP_W +: STEP_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (|req) state_nx = S_GRANT;
            S_GRANT: state_nx = (cur_steps != '0) ? S_STEP : S_CHECK;
            S_STEP:  if (cnt == STEP_W'(1)) state_nx = S_CHECK;
            S_CHECK: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            gnt   <= '0;
            din   <= 1'b0;
            exp_z <= 2'd0;
            err   <= 1'b0;
            last  <= LAST_RST;
            widx  <= 3'd0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            // din is high exactly while the FSM sits in STEP, aligned with the counter's sampling edges.
            din   <= (state_nx == S_STEP);
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt  <= arb_win;
                        widx <= arb_idx;
                    end
                end
                S_GRANT: begin
                    cnt   <= cur_steps;
                    exp_z <= z + cur_steps[1:0];
                end
                S_STEP: begin
                    cnt <= cnt - STEP_W'(1);
                end
                S_CHECK: begin
                    if (z != exp_z) err <= 1'b1;
                end
                S_DONE: begin
                    last <= widx;
                    gnt  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) ? gnt : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_fsm_counter_sched.sv
// Bench for fsm_counter_sched: models the external mod-4 counter and checks each
// operation cycle by cycle against a round-robin / modular-arithmetic reference.
module tb_fsm_counter_sched;
    import fsm_counter_pkg::*;

    localparam int N  = 3;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*SW-1:0] steps;
    logic [N-1:0]  gnt, done;
    logic          busy, din, err;
    logic [1:0]    z, exp_z;
    state_t        dbg_state;

    logic [1:0]    z_cnt;
    logic          z_load;
    logic [1:0]    z_load_val;
    logic          z_force_en;
    logic [1:0]    z_force;

    int n_cmp = 0;
    int n_bad = 0;
    int model_last;
    bit model_err;

    fsm_counter_sched #(.N_REQ(N), .STEP_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .steps     (steps),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .din       (din),
        .z         (z),
        .exp_z     (exp_z),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // External counter: advances on din, never reset by the scheduler.
    always @(posedge clk) begin
        if (z_load) z_cnt <= z_load_val;
        else if (din) z_cnt <= z_cnt + 2'd1;
    end

    assign z = z_force_en ? z_force : z_cnt;

    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (model_last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N*SW-1:0] pack_steps(input int a, input int b, input int c);
        logic [N*SW-1:0] v;
        v = '0;
        v[0*SW +: SW] = SW'(a);
        v[1*SW +: SW] = SW'(b);
        v[2*SW +: SW] = SW'(c);
        return v;
    endfunction

    // Preload the external counter; called at a negedge with the DUT idle.
    task automatic set_z(input logic [1:0] v);
        req        = '0;
        z_load     = 1'b1;
        z_load_val = v;
        @(negedge clk);
        z_load     = 1'b0;
    endtask

    // Starts at the negedge of an IDLE cycle, ends at the negedge of the next IDLE cycle.
    task automatic run_op(input string tag, input logic [N-1:0] r, input logic [N*SW-1:0] sv,
                          input bit drop, input bit inject);
        int         w, s;
        logic [1:0] z0, ez;
        logic [N-1:0] oh;
        logic [2*N+1:0] obs, want;
        w  = model_pick(r);
        s  = int'(sv[w*SW +: SW]);
        z0 = z_cnt;
        ez = z0 + 2'(s);
        oh = N'(1) << w;
        req   = r;
        steps = sv;
        for (int c = 1; c <= s + 4; c++) begin
            @(negedge clk);
            obs  = {gnt, done, busy, din};
            want = {(c <= s + 3) ? oh : '0, (c == s + 3) ? oh : '0,
                    (c <= s + 3), (c >= 2 && c <= s + 1)};
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL %s cyc%0d {gnt,done,busy,din}: got %b want %b", tag, c, obs, want);
            end
            if (c == 1) begin
                n_cmp++;
                if (err !== model_err) begin
                    n_bad++;
                    $display("FAIL %s err@grant: got %b want %b", tag, err, model_err);
                end
                if (drop) req = '0;
            end
            if (c == s + 2) begin
                n_cmp++;
                if (exp_z !== ez) begin
                    n_bad++;
                    $display("FAIL %s exp_z: got %0d want %0d", tag, exp_z, ez);
                end
                if (inject) begin
                    z_force    = z_cnt ^ 2'b01;
                    z_force_en = 1'b1;
                    model_err  = 1'b1;
                end
            end
            if (c == s + 3) begin
                z_force_en = 1'b0;
                n_cmp++;
                if (err !== model_err) begin
                    n_bad++;
                    $display("FAIL %s err@done: got %b want %b", tag, err, model_err);
                end
            end
        end
        model_last = w;
        req = '0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        req        = '0;
        steps      = '0;
        z_load     = 1'b1;
        z_load_val = 2'd0;
        z_force_en = 1'b0;
        z_force    = 2'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({gnt, done, busy, din} !== '0) begin
            n_bad++;
            $display("FAIL reset outs: got %b want 0", {gnt, done, busy, din});
        end
        n_cmp++;
        if (exp_z !== 2'd0) begin
            n_bad++;
            $display("FAIL reset exp_z: got %0d want 0", exp_z);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset err: got %b want 0", err);
        end
        reset      = 1'b1;
        z_load     = 1'b0;
        model_last = N - 1;
        model_err  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_z(2'd0);
        run_op("single_s3", 3'b001, pack_steps(3, 0, 0), 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        set_z(2'd3);
        run_op("wrap_s6", 3'b010, pack_steps(0, 6, 0), 1'b0, 1'b0);
        set_z(2'd3);
        run_op("wrap_s4", 3'b100, pack_steps(0, 0, 4), 1'b0, 1'b0);
        set_z(2'd1);
        run_op("wrap_s12", 3'b001, pack_steps(12, 0, 0), 1'b1, 1'b0);
    endtask

    task automatic test_zero();
        set_z(2'd2);
        run_op("zero_s0", 3'b010, pack_steps(5, 0, 7), 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) run_op("contend2", 3'b011, pack_steps(1, 1, 0), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) run_op("contend3", 3'b111, pack_steps(2, 0, 3), 1'b0, 1'b0);
    endtask

    task automatic test_fault();
        set_z(2'd0);
        run_op("fault_inj", 3'b001, pack_steps(2, 0, 0), 1'b0, 1'b1);
        run_op("fault_clean1", 3'b010, pack_steps(0, 5, 0), 1'b0, 1'b0);
        run_op("fault_clean2", 3'b100, pack_steps(0, 0, 0), 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_z(2'd1);
        req   = 3'b001;
        steps = pack_steps(8, 0, 0);
        for (int c = 1; c <= 4; c++) @(negedge clk);
        reset = 1'b0;
        req   = '0;
        @(negedge clk);
        n_cmp++;
        if ({gnt, done, busy, din} !== '0) begin
            n_bad++;
            $display("FAIL rstmid outs: got %b want 0", {gnt, done, busy, din});
        end
        n_cmp++;
        if ({exp_z, err} !== 3'b000) begin
            n_bad++;
            $display("FAIL rstmid exp_z/err: got %b want 000", {exp_z, err});
        end
        reset      = 1'b1;
        model_last = N - 1;
        model_err  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, busy} !== '0) begin
                n_bad++;
                $display("FAIL rstmid idle cyc%0d {done,busy}: got %b want 0", c, {done, busy});
            end
        end
        run_op("rstmid_after", 3'b011, pack_steps(2, 2, 0), 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) set_z(2'($urandom_range(0, 3)));
            run_op("random", N'($urandom_range(1, 7)),
                   pack_steps($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_zero();
        test_back_to_back();
        test_fault();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
